// File: rtl/ppu_palette_ports.sv
// ppu_palette_ports: CGB-style palette index/data register pairs, one palette RAM write port per channel.
// Define PPU_PAL_DEFER_EN to queue data writes made while the PPU holds the palettes; otherwise they are dropped.
module ppu_palette_ports #(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = 6,
   parameter int DEPTH  = 4,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cpu_en,
   input  logic [CH_W-1:0]         ch_sel,
   input  logic                    is_data,
   input  logic                    write,
   input  logic [7:0]              wdata,
   output logic [7:0]              rdata,
   input  logic                    palette_block,
   output logic [NUM_CH*IDX_W-1:0] pal_addr,
   output logic [NUM_CH-1:0]       pal_we,
   output logic [NUM_CH*8-1:0]     pal_wdata,
   input  logic [NUM_CH*8-1:0]     pal_rdata,
   output logic [NUM_CH-1:0]       pend_busy,
   output logic [NUM_CH-1:0]       ovf
);
   logic [7:0] ch_rd [NUM_CH];

   if (NUM_CH < 1 || NUM_CH > 8 || IDX_W < 1 || IDX_W > 7 || DEPTH < 2 || DEPTH > 16 ||
       (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("ppu_palette_ports: illegal parameter combination");
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             ai_q, ai_d;
      logic [IDX_W-1:0] idx_q, idx_d;
      logic             hit, idx_wr, dat_wr, we, rd_ok;
      logic [IDX_W-1:0] addr;
      logic [7:0]       wd, ird;
      assign hit = cpu_en & write & (ch_sel == CH_W'(c));
      // index register next state and the CPU view of it
      always_comb begin
         idx_wr = hit & !is_data;
         dat_wr = hit & is_data;
         ai_d   = idx_wr ? wdata[7] : ai_q;
         idx_d  = idx_wr ? wdata[IDX_W-1:0] : idx_q + IDX_W'(dat_wr & ai_q);
         ird    = {ai_q, 7'h7f};
         ird[IDX_W-1:0] = idx_q;
      end
      // index and auto-increment flag, cleared by reset at any time
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            ai_q  <= 1'b0;
            idx_q <= '0;
         end else begin
            ai_q  <= ai_d;
            idx_q <= idx_d;
         end
      end
`ifdef PPU_PAL_DEFER_EN
      localparam int PW = $clog2(DEPTH);
      logic [IDX_W+7:0] mem_q [DEPTH];
      logic [IDX_W+7:0] mem_d [DEPTH];
      logic [PW-1:0]    head_q, head_d;
      logic [PW:0]      cnt_q, cnt_d;
      logic             ovf_q, ovf_d, empty, full, drain, direct, push;
      // a full queue may still accept a write in a cycle that pops its head
      always_comb begin
         empty  = cnt_q == '0;
         full   = cnt_q == (PW+1)'(DEPTH);
         drain  = !palette_block & !empty;
         direct = dat_wr & !palette_block & empty;
         push   = dat_wr & !direct & (!full | drain);
         we     = !reset & (direct | drain);
         addr   = drain ? mem_q[head_q][IDX_W+7:8] : idx_q;
         wd     = drain ? mem_q[head_q][7:0] : wdata;
         rd_ok  = !palette_block & empty;
         mem_d  = mem_q;
         if (push) mem_d[head_q + cnt_q[PW-1:0]] = {idx_q, wdata};
         head_d = head_q + PW'(drain);
         cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(drain);
         ovf_d  = idx_wr ? 1'b0 : ovf_q | (dat_wr & !direct & !push);
      end
      // deferred-write queue state; reset discards anything pending
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            head_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         end else begin
            head_q <= head_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            mem_q  <= mem_d;
         end
      end
      assign pend_busy[c] = !empty;
      assign ovf[c]       = ovf_q;
`else
      // without deferral a blocked data write is simply lost
      always_comb begin
         we    = !reset & dat_wr & !palette_block;
         addr  = idx_q;
         wd    = wdata;
         rd_ok = !palette_block;
      end
      assign pend_busy[c] = 1'b0;
      assign ovf[c]       = 1'b0;
`endif
      assign ch_rd[c]                   = is_data ? (rd_ok ? pal_rdata[c*8 +: 8] : 8'hff) : ird;
      assign pal_we[c]                  = we;
      assign pal_addr[c*IDX_W +: IDX_W] = addr;
      assign pal_wdata[c*8 +: 8]        = wd;
   end

   // CPU read mux; unpopulated channel numbers read as all ones
   always_comb begin
      rdata = 8'hff;
      for (int i = 0; i < NUM_CH; i++) if (ch_sel == CH_W'(i)) rdata = ch_rd[i];
   end
endmodule

// File: tb/tb_ppu_palette_ports.sv
// tb_ppu_palette_ports: randomized scoreboard bench for ppu_palette_ports with a queue-based reference model
module tb_ppu_palette_ports;
   localparam int NC = 3;
   localparam int IW = 6;
   localparam int DP = 4;
   localparam int CW = 2;
   localparam int RD = 64;
`ifdef PPU_PAL_DEFER_EN
   localparam logic DEFER = 1'b1;
`else
   localparam logic DEFER = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b1, cpu_en = 1'b0, is_data = 1'b0, write = 1'b0, palette_block = 1'b0;
   logic [CW-1:0]    ch_sel = '0;
   logic [7:0]       wdata = '0, rdata;
   logic [NC*IW-1:0] pal_addr;
   logic [NC-1:0]    pal_we, pend_busy, ovf;
   logic [NC*8-1:0]  pal_wdata, pal_rdata;

   ppu_palette_ports #(.NUM_CH(NC), .IDX_W(IW), .DEPTH(DP), .CH_W(CW)) dut (
      .clk(clk), .reset(reset), .cpu_en(cpu_en), .ch_sel(ch_sel), .is_data(is_data),
      .write(write), .wdata(wdata), .rdata(rdata), .palette_block(palette_block),
      .pal_addr(pal_addr), .pal_we(pal_we), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata),
      .pend_busy(pend_busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // palette RAMs attached to the DUT write ports
   logic [7:0] ram [NC][RD];
   always_comb for (int c = 0; c < NC; c++) pal_rdata[c*8 +: 8] = ram[c][pal_addr[c*IW +: IW]];
   initial begin
      for (int c = 0; c < NC; c++) for (int a = 0; a < RD; a++) ram[c][a] = 8'(c * 37 + a * 3);
      forever begin
         @(posedge clk);
         for (int c = 0; c < NC; c++) if (pal_we[c]) ram[c][pal_addr[c*IW +: IW]] = pal_wdata[c*8 +: 8];
      end
   end

   // reference model: per-channel registers, pending queue and RAM image
   logic       m_ai  [NC];
   int         m_idx [NC];
   logic       m_ovf [NC];
   int         m_q   [NC][$];
   logic [7:0] mram  [NC][RD];

   typedef struct {
      logic          rd_en;
      logic [7:0]    rd;
      logic          lit_en;
      logic [7:0]    lit;
      logic [NC-1:0] we;
      logic [NC*IW-1:0] addr;
      logic [NC*8-1:0]  wd;
      logic [NC-1:0] pend;
      logic [NC-1:0] ovf;
   } rec_t;
   rec_t sb [$];
   int n_cmp = 0, n_bad = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         m_ai[c]  = 1'b0;
         m_idx[c] = 0;
         m_ovf[c] = 1'b0;
         m_q[c].delete();
      end
   endtask

   task automatic cyc(input logic en, input int ch, input logic isd, input logic wr, input logic [7:0] wd,
                      input logic blk, input logic lit_en, input logic [7:0] lit);
      rec_t r;
      @(posedge clk);
      #1;
      cpu_en = en; ch_sel = CW'(ch); is_data = isd; write = wr; wdata = wd; palette_block = blk;
      r.rd_en = !wr; r.lit_en = lit_en; r.lit = lit; r.rd = 8'hff;
      if (ch < NC) r.rd = isd ? ((!blk && m_q[ch].size() == 0) ? mram[ch][m_idx[ch]] : 8'hff)
                              : {m_ai[ch], 1'b1, IW'(m_idx[ch])};
      r.we = '0; r.addr = '0; r.wd = '0;
      for (int c = 0; c < NC; c++) begin
         logic hit;
         int   e;
         hit = en && wr && ch == c;
         r.pend[c] = m_q[c].size() != 0;
         r.ovf[c]  = m_ovf[c];
         r.addr[c*IW +: IW] = IW'(m_idx[c]);
         if (!blk && m_q[c].size() != 0) begin
            e = m_q[c].pop_front();
            r.we[c] = 1'b1;
            r.addr[c*IW +: IW] = IW'(e >> 8);
            r.wd[c*8 +: 8] = 8'(e);
         end
         if (hit && !isd) begin
            m_ai[c]  = wd[7];
            m_idx[c] = int'(wd) % RD;
            m_ovf[c] = 1'b0;
         end else if (hit) begin
            if (!blk && !r.pend[c]) begin
               r.we[c] = 1'b1;
               r.addr[c*IW +: IW] = IW'(m_idx[c]);
               r.wd[c*8 +: 8] = wd;
            end else if (DEFER && m_q[c].size() < DP) m_q[c].push_back(m_idx[c] * 256 + int'(wd));
            else if (DEFER) m_ovf[c] = 1'b1;
            if (m_ai[c]) m_idx[c] = (m_idx[c] + 1) % RD;
         end
         if (r.we[c]) mram[c][r.addr[c*IW +: IW]] = r.wd[c*8 +: 8];
      end
      sb.push_back(r);
   endtask

   task automatic wi(input int ch, input logic [7:0] v, input logic blk);
      cyc(1'b1, ch, 1'b0, 1'b1, v, blk, 1'b0, 8'h00);
   endtask
   task automatic wdt(input int ch, input logic [7:0] v, input logic blk);
      cyc(1'b1, ch, 1'b1, 1'b1, v, blk, 1'b0, 8'h00);
   endtask
   task automatic rdc(input int ch, input logic isd, input logic blk, input logic le, input logic [7:0] lit);
      cyc(1'b1, ch, isd, 1'b0, 8'h00, blk, le, lit);
   endtask
   task automatic idle(input logic blk);
      cyc(1'b1, 0, 1'b0, 1'b0, 8'h00, blk, 1'b0, 8'h00);
   endtask

   task automatic reset_mid();
      @(negedge clk);
      #1;
      chk("pre_reset_we1", int'(pal_we[1]), int'(DEFER));
      ch_sel = '0; is_data = 1'b0;
      reset = 1'b1;
      #1;
      chk("reset_we", pal_we, 0);
      chk("reset_pend", pend_busy, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_addr", pal_addr, 0);
      chk("reset_rdata", rdata, 8'h40);
      @(negedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // monitor: one scoreboard record per stimulus cycle, compared mid-cycle
   initial forever begin : mon
      rec_t r;
      @(negedge clk);
      if (sb.size() != 0) begin
         r = sb.pop_front();
         for (int c = 0; c < NC; c++) begin
            chk($sformatf("we[%0d]", c), pal_we[c], r.we[c]);
            chk($sformatf("addr[%0d]", c), pal_addr[c*IW +: IW], r.addr[c*IW +: IW]);
            if (r.we[c]) chk($sformatf("wdata[%0d]", c), pal_wdata[c*8 +: 8], r.wd[c*8 +: 8]);
            chk($sformatf("pend_busy[%0d]", c), pend_busy[c], r.pend[c]);
            chk($sformatf("ovf[%0d]", c), ovf[c], r.ovf[c]);
         end
         if (r.rd_en) chk("rdata", rdata, r.rd);
         if (r.lit_en) chk("rdata_const", rdata, r.lit);
      end
   end

   initial begin
      logic blk_r;
      for (int c = 0; c < NC; c++) for (int a = 0; a < RD; a++) mram[c][a] = 8'(c * 37 + a * 3);
      model_reset();
      #2;
      chk("por_rdata", rdata, 8'h40);
      chk("por_we", pal_we, 0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      rdc(0, 1'b0, 1'b0, 1'b1, 8'h40);
      wi(0, 8'h80, 1'b0);
      wdt(0, 8'hAA, 1'b0);
      wdt(0, 8'hBB, 1'b0);
      wdt(0, 8'hCC, 1'b0);
      rdc(0, 1'b0, 1'b0, 1'b1, 8'hC3);
      wi(0, 8'h80, 1'b0);
      rdc(0, 1'b1, 1'b0, 1'b1, 8'hAA);
      wi(0, 8'hBF, 1'b0);
      wdt(0, 8'hDD, 1'b0);
      rdc(0, 1'b0, 1'b0, 1'b1, 8'hC0);
      wi(1, 8'h85, 1'b1);
      wdt(1, 8'h11, 1'b1);
      wdt(1, 8'h22, 1'b1);
      wdt(1, 8'h33, 1'b1);
      rdc(1, 1'b1, 1'b1, 1'b1, 8'hFF);
      repeat (3) idle(1'b0);
      rdc(1, 1'b0, 1'b0, 1'b1, 8'hC8);
      wi(1, 8'h80, 1'b1);
      for (int i = 0; i < 5; i++) wdt(1, 8'(8'h60 + i), 1'b1);
      repeat (5) idle(1'b0);
      wi(1, 8'h80, 1'b0);
      idle(1'b0);
      wi(1, 8'h90, 1'b1);
      wdt(1, 8'h01, 1'b1);
      wdt(1, 8'h02, 1'b1);
      wdt(1, 8'h44, 1'b0);
      repeat (2) idle(1'b0);
      wi(0, 8'h83, 1'b0);
      wdt(0, 8'h55, 1'b1);
      rdc(0, 1'b0, 1'b1, 1'b1, 8'hC4);
      rdc(0, 1'b1, 1'b0, 1'b0, 8'h00);
      wdt(3, 8'h77, 1'b0);
      rdc(3, 1'b0, 1'b0, 1'b1, 8'hFF);
      rdc(3, 1'b1, 1'b0, 1'b1, 8'hFF);
      wi(1, 8'h80, 1'b1);
      wdt(1, 8'hA1, 1'b1);
      wdt(1, 8'hA2, 1'b1);
      wdt(1, 8'hA3, 1'b1);
      idle(1'b0);
      reset_mid();
      rdc(1, 1'b0, 1'b0, 1'b1, 8'h40);
      blk_r = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) blk_r = !blk_r;
         cyc($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2) != 0, 8'($urandom), blk_r, 1'b0, 8'h00);
      end
      repeat (3) @(negedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
